// File: rtl/ras_pkg.sv
// Return-address stack shared types and default geometry.
package ras_pkg;

    localparam int RAS_DEPTH = 32;
    localparam int RAS_AW    = 5;
    localparam int RAS_DW    = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH,
        S_POP_RD,
        S_POP_OUT,
        S_DONE
    } ras_state_e;

endpackage

// File: rtl/ras_mem.sv
// RAS storage: one write port, one synchronous read port, no reset.
module ras_mem
    import ras_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH,
    parameter int AW    = RAS_AW,
    parameter int DW    = RAS_DW
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/ras_ctrl.sv
// Return-address stack sequencer: req/done handshake, pointer and
// occupancy tracking, sticky overflow/underflow.
module ras_ctrl
    import ras_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH,
    parameter int AW    = RAS_AW,
    parameter int DW    = RAS_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          call_req,
    input  logic          ret_req,
    input  logic [DW-1:0] call_pc,
    input  logic          flush,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] ret_pc,
    output logic          ret_valid,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    ras_state_e    state_q;
    logic [AW-1:0] sp_q;
    logic [AW:0]   count_q;
    logic [DW-1:0] pc_q;
    logic [DW-1:0] ret_pc_q;
    logic [DW-1:0] rd_data;
    logic          busy_q, done_q, valid_q;
    logic          ovf_q, unf_q;
    logic          mem_we;
    logic [AW-1:0] rd_addr;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;

    assign busy      = busy_q;
    assign done      = done_q;
    assign ret_pc    = ret_pc_q;
    assign ret_valid = valid_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

    // A flush landing in PUSH must not commit the write.
    assign mem_we  = (state_q == S_PUSH) && !flush;
    assign rd_addr = sp_q - AW'(1);

    ras_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (sp_q),
        .wdata_i (pc_q),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sp_q     <= '0;
            count_q  <= '0;
            pc_q     <= '0;
            ret_pc_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else if (flush) begin
            state_q <= S_IDLE;
            sp_q    <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (call_req) begin
                        pc_q    <= call_pc;
                        state_q <= S_PUSH;
                        busy_q  <= 1'b1;
                    end else if (ret_req) begin
                        state_q <= S_POP_RD;
                        busy_q  <= 1'b1;
                    end
                end
                S_PUSH: begin
                    sp_q <= sp_q + AW'(1);
                    // Full stack wraps and overwrites the oldest entry.
                    if (full) begin
                        ovf_q <= 1'b1;
                    end else begin
                        count_q <= count_q + (AW+1)'(1);
                    end
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
                S_POP_RD: begin
                    if (empty) begin
                        unf_q   <= 1'b1;
                        valid_q <= 1'b0;
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        sp_q    <= rd_addr;
                        count_q <= count_q - (AW+1)'(1);
                        state_q <= S_POP_OUT;
                    end
                end
                S_POP_OUT: begin
                    ret_pc_q <= rd_data;
                    valid_q  <= 1'b1;
                    state_q  <= S_DONE;
                    done_q   <= 1'b1;
                end
                S_DONE: begin
                    if (!call_req && !ret_req) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed-vector bench for ras_ctrl with hand-computed expectations.
module tb_ras_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        call_req;
    logic        ret_req;
    logic [31:0] call_pc;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] ret_pc;
    logic        ret_valid;
    logic        full;
    logic        empty;
    logic [5:0]  count;
    logic        overflow;
    logic        underflow;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    ras_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .call_req  (call_req),
        .ret_req   (ret_req),
        .call_pc   (call_pc),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .ret_pc    (ret_pc),
        .ret_valid (ret_valid),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h exp 0x%0h", tag, got, exp);
        end
    endtask

    // Counts edges, including the accepting one, until done is seen.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!done && n < 20);
    endtask

    task automatic do_call(input logic [31:0] pc, input int exp_lat);
        int n;
        @(negedge clk);
        call_pc  = pc;
        call_req = 1'b1;
        wait_done(n);
        chk("call_lat", 64'(n), 64'(exp_lat));
        call_req = 1'b0;
        @(negedge clk);
        chk("call_idle", 64'(busy), 64'd0);
    endtask

    task automatic do_ret(input int exp_lat,
                          input logic [31:0] exp_pc,
                          input logic exp_vld);
        int n;
        @(negedge clk);
        ret_req = 1'b1;
        wait_done(n);
        chk("ret_lat", 64'(n), 64'(exp_lat));
        chk("ret_pc", 64'(ret_pc), 64'(exp_pc));
        chk("ret_valid", 64'(ret_valid), 64'(exp_vld));
        ret_req = 1'b0;
        @(negedge clk);
        chk("ret_idle", 64'(busy), 64'd0);
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        call_req = 1'b1;
        ret_req  = 1'b0;
        call_pc  = 32'hDEAD;
        flush    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_retpc", 64'(ret_pc), 64'd0);
        chk("rst_valid", 64'(ret_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_unf", 64'(underflow), 64'd0);
        call_req = 1'b0;
        rst_n    = 1'b1;

        do_call(32'h100, 2);
        do_call(32'h200, 2);
        do_call(32'h300, 2);
        chk("cnt3", 64'(count), 64'd3);
        do_ret(3, 32'h300, 1'b1);
        do_ret(3, 32'h200, 1'b1);
        do_ret(3, 32'h100, 1'b1);
        chk("pop_empty", 64'(empty), 64'd1);
        chk("pop_cnt0", 64'(count), 64'd0);

        do_ret(2, 32'h100, 1'b0);
        chk("unf_set", 64'(underflow), 64'd1);
        chk("unf_cnt", 64'(count), 64'd0);

        do_flush();
        chk("flush_unf", 64'(underflow), 64'd0);

        for (int i = 0; i < 32; i++) begin
            do_call(32'h1000 + 32'(4 * i), 2);
        end
        chk("full32", 64'(full), 64'd1);
        chk("ovf_pre", 64'(overflow), 64'd0);
        chk("cnt32", 64'(count), 64'd32);
        do_call(32'h1080, 2);
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("cnt_sat", 64'(count), 64'd32);
        do_ret(3, 32'h1080, 1'b1);
        chk("cnt31", 64'(count), 64'd31);

        do_flush();
        chk("flush_cnt", 64'(count), 64'd0);
        chk("flush_ovf", 64'(overflow), 64'd0);

        do_call(32'h20, 2);
        begin
            int n;
            @(negedge clk);
            call_pc  = 32'h44;
            call_req = 1'b1;
            ret_req  = 1'b1;
            wait_done(n);
            chk("both_lat", 64'(n), 64'd2);
            chk("both_cnt", 64'(count), 64'd2);
            call_req = 1'b0;
            ret_req  = 1'b0;
            @(negedge clk);
        end
        do_ret(3, 32'h44, 1'b1);
        do_ret(3, 32'h20, 1'b1);

        do_ret(2, 32'h20, 1'b0);
        chk("unf_again", 64'(underflow), 64'd1);
        do_call(32'h55, 2);
        chk("pre_fl_cnt", 64'(count), 64'd1);
        @(negedge clk);
        ret_req = 1'b1;
        @(negedge clk);
        chk("in_poprd", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        chk("fl_busy", 64'(busy), 64'd0);
        chk("fl_done", 64'(done), 64'd0);
        chk("fl_cnt", 64'(count), 64'd0);
        chk("fl_unf", 64'(underflow), 64'd0);
        chk("fl_retpc", 64'(ret_pc), 64'h20);
        ret_req = 1'b0;
        flush   = 1'b0;
        repeat (3) @(negedge clk);
        chk("fl_nodone", 64'(done), 64'd0);
        chk("fl_novld", 64'(ret_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, errs);
        $finish;
    end

endmodule
